// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: owns the PC, drives the imem address and registers the fetched word into IF/ID.
// Define IF_PERF_CNT_EN to build the saturating stall/flush perf counters; otherwise they read as zero.
module if_stage_pipe #(
  parameter int                    PC_WIDTH   = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = 64'h0,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]   if_id_pc,
  output logic [INST_WIDTH-1:0] if_id_inst,
  output logic                  if_id_valid,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
);

  localparam logic [PC_WIDTH-1:0] PC_ZERO = {PC_WIDTH{1'b0}};
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(3'd4);

  logic [PC_WIDTH-1:0]   pc_r;
  logic [PC_WIDTH-1:0]   if_id_pc_r;
  logic [INST_WIDTH-1:0] if_id_inst_r;
  logic                  if_id_valid_r;
  logic [PC_WIDTH-1:0]   redirect_pc_s;

  // Redirects are forced onto a word boundary.
  assign redirect_pc_s = {branch_target[PC_WIDTH-1:2], 2'b00};

  assign imem_addr   = pc_r;
  assign if_id_pc    = if_id_pc_r;
  assign if_id_inst  = if_id_inst_r;
  assign if_id_valid = if_id_valid_r;

  // PC and IF/ID update: redirect beats stall, stall beats fetch-disable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      if_id_pc_r    <= PC_ZERO;
      if_id_inst_r  <= NOP_INST;
      if_id_valid_r <= 1'b0;
    end else if (branch_taken) begin
      pc_r          <= redirect_pc_s;
      if_id_pc_r    <= PC_ZERO;
      if_id_inst_r  <= NOP_INST;
      if_id_valid_r <= 1'b0;
    end else if (stall) begin
      pc_r          <= pc_r;
      if_id_pc_r    <= if_id_pc_r;
      if_id_inst_r  <= if_id_inst_r;
      if_id_valid_r <= if_id_valid_r;
    end else if (!fetch_en) begin
      pc_r          <= pc_r;
      if_id_pc_r    <= PC_ZERO;
      if_id_inst_r  <= NOP_INST;
      if_id_valid_r <= 1'b0;
    end else begin
      pc_r          <= pc_r + PC_STEP;
      if_id_pc_r    <= pc_r;
      if_id_inst_r  <= imem_rdata;
      if_id_valid_r <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Saturating event counters; a redirect edge counts only as a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= 32'h0;
      flush_cnt_r <= 32'h0;
    end else if (branch_taken) begin
      stall_cnt_r <= stall_cnt_r;
      if (flush_cnt_r != 32'hFFFF_FFFF) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end else if (stall) begin
      flush_cnt_r <= flush_cnt_r;
      if (stall_cnt_r != 32'hFFFF_FFFF) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end else begin
      stall_cnt_r <= stall_cnt_r;
      flush_cnt_r <= flush_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = 32'h0;
  assign flush_cnt = 32'h0;
`endif

endmodule
